// File: rtl/seq_digit_mult.sv
// Digit-serial multiplier: WIDTH x WIDTH -> 2*WIDTH, DIGIT bits of B per cycle, optional two's complement.
// Latency: output_tvalid rises WIDTH/DIGIT edges after the later operand handshake.
// Backpressure: product and valid hold while output_tready=0; input treadys stay low until the product is taken.
module seq_digit_mult #(
    parameter int WIDTH  = 16,
    parameter int DIGIT  = 4,
    parameter int SIGNED = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     input_a_tdata,
    input  logic                 input_a_tvalid,
    output logic                 input_a_tready,
    input  logic [WIDTH-1:0]     input_b_tdata,
    input  logic                 input_b_tvalid,
    output logic                 input_b_tready,
    output logic [2*WIDTH-1:0]   output_tdata,
    output logic                 output_tvalid,
    input  logic                 output_tready
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NDIG - 1);

    generate
        if (WIDTH % DIGIT != 0) begin : g_bad_digit
            $error("seq_digit_mult: DIGIT must divide WIDTH exactly");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic                 a_held;
    logic                 b_held;
    logic                 a_sign;
    logic                 b_sign;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_sr;      // magnitude of B, shifted right one digit per compute cycle
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   acc;

    logic                 a_fire;
    logic                 b_fire;
    logic                 out_fire;
    logic                 a_in_neg;
    logic                 b_in_neg;
    logic [WIDTH-1:0]     a_in_mag;
    logic [WIDTH-1:0]     b_in_mag;
    logic [WIDTH+DIGIT-1:0] pp;
    logic [2*WIDTH-1:0]   partial;
    logic [2*WIDTH-1:0]   sum;
    logic [2*WIDTH-1:0]   result;

    // Operand acceptance only while idle and not yet holding that operand.
    assign input_a_tready = (state == ST_IDLE) && !a_held;
    assign input_b_tready = (state == ST_IDLE) && !b_held;
    assign a_fire   = input_a_tvalid && input_a_tready;
    assign b_fire   = input_b_tvalid && input_b_tready;
    assign out_fire = output_tvalid && output_tready;

    // Sign/magnitude split on capture; -2^(WIDTH-1) maps to 2^(WIDTH-1), which still fits unsigned.
    assign a_in_neg = (SIGNED != 0) && input_a_tdata[WIDTH-1];
    assign b_in_neg = (SIGNED != 0) && input_b_tdata[WIDTH-1];
    assign a_in_mag = a_in_neg ? (WIDTH'(0) - input_a_tdata) : input_a_tdata;
    assign b_in_mag = b_in_neg ? (WIDTH'(0) - input_b_tdata) : input_b_tdata;

    // One digit partial product, aligned to the digit position and added to the running sum.
    assign pp      = (WIDTH+DIGIT)'(a_mag) * (WIDTH+DIGIT)'(b_sr[DIGIT-1:0]);
    assign partial = (2*WIDTH)'(pp) << (DIGIT * int'(cnt));
    assign sum     = acc + partial;
    assign result  = ((SIGNED != 0) && (a_sign ^ b_sign)) ? ((2*WIDTH)'(0) - sum) : sum;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: start once both operands are held, finish after the last digit.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if ((a_held || a_fire) && (b_held || b_fire)) begin
                    state_nxt = ST_CALC;
                end
            end
            ST_CALC: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (output_tready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Operand capture and held flags; B digits are consumed LSB first by shifting.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_held <= 1'b0;
            b_held <= 1'b0;
            a_sign <= 1'b0;
            b_sign <= 1'b0;
            a_mag  <= '0;
            b_sr   <= '0;
        end else begin
            if (a_fire) begin
                a_mag  <= a_in_mag;
                a_sign <= a_in_neg;
                a_held <= 1'b1;
            end
            if (b_fire) begin
                b_sr   <= b_in_mag;
                b_sign <= b_in_neg;
                b_held <= 1'b1;
            end
            if (state == ST_CALC) begin
                b_sr <= b_sr >> DIGIT;
            end
            if (out_fire) begin
                a_held <= 1'b0;
                b_held <= 1'b0;
            end
        end
    end

    // Accumulator, digit counter and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc           <= '0;
            cnt           <= '0;
            output_tdata  <= '0;
            output_tvalid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    acc <= '0;
                    cnt <= '0;
                end
                ST_CALC: begin
                    acc <= sum;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        output_tdata  <= result;
                        output_tvalid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (output_tready) begin
                        output_tvalid <= 1'b0;
                    end
                end
                default: begin
                    acc <= '0;
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule
